uart_adder_host: RTL

Host-side requester for the two-byte UART adder protocol. On a start pulse it sends operand bytes A then B through a `uart` instance. It then collects the 3-byte reply (A echo, B echo, A+B mod 256), checks the reply against the expected values and reports the sum plus a status word. It sits on the initiator FPGA (or in a loopback bench) opposite the adder top, and drives the same `uart` byte-level handshake.

---
 rtl/adder_proto_pkg.sv | 36 +++
 rtl/rx_timeout_counter.sv | 36 +++
 rtl/uart_adder_host.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_proto_pkg.sv
// Shared definitions for the two-byte UART adder protocol.
//   state_t      : host requester FSM states
//   STATUS_*     : bit positions inside the 4-bit status word
//   REQ_BYTES    : operand bytes sent per request
//   RSP_BYTES    : reply bytes expected per request (A echo, B echo, sum)
//   add_mod256() : protocol sum, 9-bit add truncated to 8 bits
package adder_proto_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SEND_A = 4'd1,
    ST_WAIT_A = 4'd2,
    ST_SEND_B = 4'd3,
    ST_WAIT_B = 4'd4,
    ST_RX_A   = 4'd5,
    ST_RX_B   = 4'd6,
    ST_RX_S   = 4'd7,
    ST_FINISH = 4'd8
  } state_t;

  localparam int unsigned STATUS_ECHO    = 0;
  localparam int unsigned STATUS_SUM     = 1;
  localparam int unsigned STATUS_FRAME   = 2;
  localparam int unsigned STATUS_TIMEOUT = 3;
  localparam int unsigned STATUS_W       = 4;

  localparam int unsigned REQ_BYTES = 2;
  localparam int unsigned RSP_BYTES = 3;

  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w_full;
    w_full = {1'b0, a} + {1'b0, b};
    return w_full[7:0];
  endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Idle-cycle counter guarding the reply phase.
//   iCE_CLK : clock
//   rst_n   : asynchronous active-low reset
//   clear   : restart the count from zero on the next edge
//   enable  : count while high
//   expired : high in the cycle at whose end the count reaches
//             TIMEOUT_CYCLES-1, so the owner can abort on that same edge
// TIMEOUT_CYCLES must be at least 2.
module rx_timeout_counter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
  input  logic iCE_CLK,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [23:0] r_count;

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 24'd1;
    end
  end

  // Flagged one step early: the abort edge is the edge on which the
  // count would become TIMEOUT_CYCLES-1, so the owner's done pulse
  // lands exactly TIMEOUT_CYCLES cycles after the last clear.
  assign expired = enable && !clear && (r_count == (TIMEOUT_CYCLES - 24'd2));

endmodule

// File: rtl/uart_adder_host.sv
// Host-side requester for the two-byte UART adder protocol.
// On an accepted start it sends op_a then op_b through the uart byte
// handshake, collects the 3-byte reply (A echo, B echo, sum), and reports
// the sum with a status word {timeout, frame_err, sum_err, echo_err}.
//   iCE_CLK, rst_n     : clock, asynchronous active-low reset
//   start, op_a, op_b  : request strobe and operands (sampled in IDLE)
//   busy, done         : transaction in flight / one-cycle completion
//   sum, status        : result, valid with done, held until next done
//   transmit, tx_byte  : uart transmit request and byte
//   is_transmitting    : uart transmitter busy
//   received, rx_byte  : uart receive strobe and byte
//   recv_error         : uart framing error strobe
module uart_adder_host
  import adder_proto_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
  input  logic                iCE_CLK,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          op_a,
  input  logic [7:0]          op_b,
  output logic                busy,
  output logic                done,
  output logic [7:0]          sum,
  output logic [STATUS_W-1:0] status,
  output logic                transmit,
  output logic [7:0]          tx_byte,
  input  logic                is_transmitting,
  input  logic                received,
  input  logic [7:0]          rx_byte,
  input  logic                recv_error
);

  state_t              r_state;
  state_t              w_next_state;

  logic [7:0]          r_op_a;
  logic [7:0]          r_op_b;
  logic [7:0]          r_echo_a;
  logic [7:0]          r_echo_b;
  logic [7:0]          r_sum;
  logic [STATUS_W-1:0] r_status;
  logic                r_transmit;
  logic [7:0]          r_tx_byte;

  logic [7:0]          w_op_a;
  logic [7:0]          w_op_b;
  logic [7:0]          w_echo_a;
  logic [7:0]          w_echo_b;
  logic [7:0]          w_sum;
  logic [STATUS_W-1:0] w_status;
  logic                w_transmit;
  logic [7:0]          w_tx_byte;

  logic                w_in_rx;
  logic                w_tmo_clear;
  logic                w_expired;

  assign w_in_rx     = (r_state == ST_RX_A) || (r_state == ST_RX_B) || (r_state == ST_RX_S);
  // Cleared outside the reply phase, which covers the entry into RX_A.
  assign w_tmo_clear = !w_in_rx || received;

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .iCE_CLK (iCE_CLK),
    .rst_n   (rst_n),
    .clear   (w_tmo_clear),
    .enable  (w_in_rx),
    .expired (w_expired)
  );

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // sum/status are loaded on the edge entering FINISH (using the live
  // rx_byte for the third byte) so they are already valid while done is high.
  always_comb begin
    w_next_state = r_state;
    w_op_a       = r_op_a;
    w_op_b       = r_op_b;
    w_echo_a     = r_echo_a;
    w_echo_b     = r_echo_b;
    w_sum        = r_sum;
    w_status     = r_status;
    w_transmit   = r_transmit;
    w_tx_byte    = r_tx_byte;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_op_a       = op_a;
          w_op_b       = op_b;
          w_next_state = ST_SEND_A;
        end
      end

      ST_SEND_A: begin
        if (!is_transmitting) begin
          w_transmit   = 1'b1;
          w_tx_byte    = r_op_a;
          w_next_state = ST_WAIT_A;
        end
      end

      ST_WAIT_A: begin
        if (is_transmitting) begin
          w_transmit   = 1'b0;
          w_next_state = ST_SEND_B;
        end
      end

      ST_SEND_B: begin
        if (!is_transmitting) begin
          w_transmit   = 1'b1;
          w_tx_byte    = r_op_b;
          w_next_state = ST_WAIT_B;
        end
      end

      ST_WAIT_B: begin
        if (is_transmitting) begin
          w_transmit   = 1'b0;
          w_next_state = ST_RX_A;
        end
      end

      ST_RX_A, ST_RX_B, ST_RX_S: begin
        if (recv_error) begin
          w_sum                  = '0;
          w_status               = '0;
          w_status[STATUS_FRAME] = 1'b1;
          w_next_state           = ST_FINISH;
        end else if (received) begin
          if (r_state == ST_RX_A) begin
            w_echo_a     = rx_byte;
            w_next_state = ST_RX_B;
          end else if (r_state == ST_RX_B) begin
            w_echo_b     = rx_byte;
            w_next_state = ST_RX_S;
          end else begin
            w_sum                 = rx_byte;
            w_status              = '0;
            w_status[STATUS_SUM]  = (rx_byte != add_mod256(r_op_a, r_op_b));
            w_status[STATUS_ECHO] = (r_echo_a != r_op_a) || (r_echo_b != r_op_b);
            w_next_state          = ST_FINISH;
          end
        end else if (w_expired) begin
          w_sum                    = '0;
          w_status                 = '0;
          w_status[STATUS_TIMEOUT] = 1'b1;
          w_next_state             = ST_FINISH;
        end
      end

      ST_FINISH: begin
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_echo_a   <= '0;
      r_echo_b   <= '0;
      r_sum      <= '0;
      r_status   <= '0;
      r_transmit <= 1'b0;
      r_tx_byte  <= '0;
    end else begin
      r_op_a     <= w_op_a;
      r_op_b     <= w_op_b;
      r_echo_a   <= w_echo_a;
      r_echo_b   <= w_echo_b;
      r_sum      <= w_sum;
      r_status   <= w_status;
      r_transmit <= w_transmit;
      r_tx_byte  <= w_tx_byte;
    end
  end

  assign busy     = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign done     = (r_state == ST_FINISH);
  assign sum      = r_sum;
  assign status   = r_status;
  assign transmit = r_transmit;
  assign tx_byte  = r_tx_byte;

endmodule
